estagio_busca: RTL and testbench
================================

# estagio_busca

Instruction-fetch stage feeding the 16 x 16-bit instruction memory. It owns the program counter, drives the memory address each cycle, and absorbs the memory's one-cycle registered read latency. It presents the fetched word to the decode stage over a valid/ready handshake and accepts jump redirects from downstream. Optionally, it owns a loader port that writes program words into the memory.

## Interface
- ADDR_W, 4, instruction-memory address width (16 words)
- DATA_W, 16, instruction width
- Clock  in  1  rising-edge clock, shared with the instruction memory
- Reset  in  1  asynchronous, active-high; also routed to the memory, so it must span at least one Clock edge to reinitialise memory contents
- ID_Ready  in  1  decode accepts Instr this cycle
- Jump  in  1  redirect request from downstream
- JumpTarget  in  ADDR_W  redirect address
- Mem_Q  in  DATA_W  memory read data (registered in memory)
- Mem_Address  out  ADDR_W  memory address (combinational)
- Mem_Wren  out  1  memory write enable
- Mem_Din  out  DATA_W  memory write data
- IF_Valid  out  1  Instr/PC_out hold a valid fetched instruction
- Instr  out  DATA_W  fetched instruction; 16'h0000 (NOP) when IF_Valid=0
- PC_out  out  ADDR_W  address of Instr
- Load_Valid, Load_Addr[ADDR_W], Load_Data[DATA_W]  in  loader port, present only with BUSCA_LOADER_EN

## Operation
- State is held in these registers:
  - pc_q: address of the word currently on Mem_Q.
  - valid_q: Mem_Q is meaningful.
  - st: the FSM state, one of PRIME, RUN, LOAD.
- PRIME: entered on reset and on loader exit. Drives Mem_Address=pc_q. IF_Valid=0. Goes to RUN next edge with valid_q=1.
- RUN: IF_Valid = valid_q & ~Jump. Instr = Mem_Q. PC_out = pc_q.
- Next-address priority in RUN/PRIME is Jump, then ~ID_Ready (hold), then advance:
  - Jump=1: Mem_Address=JumpTarget; the current word is squashed.
  - IF_Valid=1 and ID_Ready=0: Mem_Address=pc_q. The memory re-reads the same word, so Instr stays stable.
  - Otherwise: Mem_Address=pc_q+1, modulo 2^ADDR_W (15 wraps to 0).
- Every edge in PRIME/RUN: pc_q <= Mem_Address.
- A transfer occurs when IF_Valid & ID_Ready. Each word is delivered exactly once unless squashed by Jump.
- Mem_Wren=0 and Mem_Din=0 outside LOAD.
- No decoding of opcodes: NOP words are fetched and delivered like any other.

## Timing
- Reset (asynchronous) forces: pc_q=0, valid_q=0, st=PRIME, IF_Valid=0, Instr=0, PC_out=0, Mem_Address=0, Mem_Wren=0, Mem_Din=0.
- First valid instruction is presented in the second cycle after Reset deasserts (one PRIME cycle).
- Throughput: one instruction per cycle with ID_Ready=1.
- Redirect latency: Jump asserted in cycle n gives IF_Valid=0 in cycle n and mem[JumpTarget] valid in cycle n+1. Jump during a stall or during PRIME is honoured identically.
- Combinational paths exist from ID_Ready, Jump, JumpTarget and Load_* to Mem_Address. There is no combinational path from Mem_Q to any output except Instr.
- Reset mid-operation: outputs return to reset values immediately. The pending word is discarded and fetch restarts at 0.

## Configuration
- BUSCA_LOADER_EN defined:
  - The Load_* ports exist and the LOAD state is added.
  - Load_Valid=1 has priority over everything except Reset, from any state. Jump and ID_Ready are ignored.
  - In LOAD: Mem_Wren=1, Mem_Address=Load_Addr, Mem_Din=Load_Data, IF_Valid=0.
  - First edge with Load_Valid=0: pc_q=0, st=PRIME.
- Not defined: the ports and the LOAD state are absent, and Mem_Wren/Mem_Din are tied to 0.

## Structure
- Shared package isa_pkg holds:
  - ADDR_W and DATA_W.
  - Field positions: opcode [15:13], rd [12:10], rs1 [9:7], rs2 [6:4].
  - Opcode constants ADD=3'd2 and SUB=3'd3.
  - NOP=16'h0000.
  - Register codes R0..R3.
  - Fetch state encoding.
- One sub-module, busca_prox_endereco: the combinational next-address priority mux. The FSM and registers stay in estagio_busca.

## Test plan
- Reset released with ID_Ready=1 and default memory: one bubble, then PC/Instr = 0/40A0, 1/60A0, 2/40A0 … 6/60A0, 7/0000.
- Continuous ID_Ready=1 for 20 transfers: PC 15 is followed by PC 0 with Instr=40A0, and no bubble at the wrap.
- ID_Ready=0 for 3 cycles while PC=1: IF_Valid=1, Instr=60A0, PC_out=1 held. After release, the next transfer is PC=2.
- Jump=1, JumpTarget=6 while PC=2: IF_Valid=0 that cycle; next cycle PC=6, Instr=60A0; then PC=7.
- Reset pulsed between clock edges while PC=4: IF_Valid=0 and PC_out=0 immediately. After release, the sequence restarts 0/40A0.
- With BUSCA_LOADER_EN: load 16'h1234 to address 3, deassert Load_Valid. Sequence is 0/40A0, 1/60A0, 2/40A0, 3/1234.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction-fetch slice: widths, field layout, opcodes and fetch FSM encoding.
// The BUSCA_LOADER_EN build macro selects the program-loader port in estagio_busca.
package isa_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;
  localparam int RD_MSB     = 12;
  localparam int RD_LSB     = 10;
  localparam int RS1_MSB    = 9;
  localparam int RS1_LSB    = 7;
  localparam int RS2_MSB    = 6;
  localparam int RS2_LSB    = 4;

  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] SUB = 3'd3;

  localparam logic [DATA_W-1:0] NOP = 16'h0000;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } fetch_st_e;

  // Sequential fetch address; wraps naturally at 2^ADDR_W
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/estagio_busca_if.sv
// Bundles the fetch stage's memory bus, decode handshake and redirect signals.
// Loader signals exist only when BUSCA_LOADER_EN is defined.
interface estagio_busca_if;
  import isa_pkg::*;

  logic              ID_Ready;
  logic              Jump;
  logic [ADDR_W-1:0] JumpTarget;
  logic [DATA_W-1:0] Mem_Q;
  logic [ADDR_W-1:0] Mem_Address;
  logic              Mem_Wren;
  logic [DATA_W-1:0] Mem_Din;
  logic              IF_Valid;
  logic [DATA_W-1:0] Instr;
  logic [ADDR_W-1:0] PC_out;
`ifdef BUSCA_LOADER_EN
  logic              Load_Valid;
  logic [ADDR_W-1:0] Load_Addr;
  logic [DATA_W-1:0] Load_Data;
`endif

  modport master (
    input  ID_Ready, Jump, JumpTarget, Mem_Q,
`ifdef BUSCA_LOADER_EN
    input  Load_Valid, Load_Addr, Load_Data,
`endif
    output Mem_Address, Mem_Wren, Mem_Din, IF_Valid, Instr, PC_out
  );

  modport slave (
    output ID_Ready, Jump, JumpTarget, Mem_Q,
`ifdef BUSCA_LOADER_EN
    output Load_Valid, Load_Addr, Load_Data,
`endif
    input  Mem_Address, Mem_Wren, Mem_Din, IF_Valid, Instr, PC_out
  );

endinterface

// File: rtl/busca_prox_endereco.sv
// Next fetch-address priority mux: redirect, then hold on stall (or while priming), then advance.
module busca_prox_endereco
  import isa_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic              prime,
  input  logic              if_valid,
  input  logic              id_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] prox_endereco
);

  // Re-reading pc on a stall keeps the registered memory output stable
  always_comb begin
    prox_endereco = pc_incr(pc);
    if (jump) begin
      prox_endereco = jump_target;
    end else if (prime || (if_valid && !id_ready)) begin
      prox_endereco = pc;
    end else begin
      prox_endereco = pc_incr(pc);
    end
  end

endmodule

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the PC, hides the memory's one-cycle read latency, valid/ready to decode.
// Define BUSCA_LOADER_EN to add the LOAD state and the program-loader port.
module estagio_busca
  import isa_pkg::*;
(
  input  logic            Clock,
  input  logic            Reset,
  estagio_busca_if.master bus
);

  fetch_st_e         st_r;
  fetch_st_e         st_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic              valid_r;
  logic              valid_nxt_s;
  logic              if_valid_s;
  logic [ADDR_W-1:0] prox_s;

  assign if_valid_s = (st_r == ST_RUN) && valid_r && !bus.Jump;

  busca_prox_endereco u_prox (
    .pc            (pc_r),
    .prime         (st_r == ST_PRIME),
    .if_valid      (if_valid_s),
    .id_ready      (bus.ID_Ready),
    .jump          (bus.Jump),
    .jump_target   (bus.JumpTarget),
    .prox_endereco (prox_s)
  );

  // FSM state, PC of the word on Mem_Q and its valid flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      st_r    <= ST_PRIME;
      pc_r    <= '0;
      valid_r <= 1'b0;
    end else begin
      st_r    <= st_nxt_s;
      pc_r    <= pc_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Next state and outputs; Reset also forces the combinational outputs low
  always_comb begin
    st_nxt_s        = st_r;
    pc_nxt_s        = pc_r;
    valid_nxt_s     = valid_r;
    bus.Mem_Address = '0;
    bus.Mem_Wren    = 1'b0;
    bus.Mem_Din     = '0;
    bus.IF_Valid    = 1'b0;
    bus.Instr       = NOP;
    bus.PC_out      = pc_r;
    if (Reset) begin
      st_nxt_s    = ST_PRIME;
      pc_nxt_s    = '0;
      valid_nxt_s = 1'b0;
      bus.PC_out  = '0;
    end
`ifdef BUSCA_LOADER_EN
    else if (bus.Load_Valid) begin
      st_nxt_s        = ST_LOAD;
      pc_nxt_s        = '0;
      valid_nxt_s     = 1'b0;
      bus.Mem_Wren    = 1'b1;
      bus.Mem_Address = bus.Load_Addr;
      bus.Mem_Din     = bus.Load_Data;
    end
`endif
    else begin
      case (st_r)
        ST_PRIME: begin
          bus.Mem_Address = prox_s;
          pc_nxt_s        = prox_s;
          valid_nxt_s     = 1'b1;
          st_nxt_s        = ST_RUN;
        end
        ST_RUN: begin
          bus.IF_Valid    = if_valid_s;
          bus.Instr       = if_valid_s ? bus.Mem_Q : NOP;
          bus.Mem_Address = prox_s;
          pc_nxt_s        = prox_s;
          valid_nxt_s     = 1'b1;
        end
`ifdef BUSCA_LOADER_EN
        ST_LOAD: begin
          pc_nxt_s    = '0;
          valid_nxt_s = 1'b0;
          st_nxt_s    = ST_PRIME;
        end
`endif
        default: begin
          pc_nxt_s    = '0;
          valid_nxt_s = 1'b0;
          st_nxt_s    = ST_PRIME;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_estagio_busca.sv
// Bench for estagio_busca: registered-read memory model, directed stimulus, queue scoreboard.
// Define BUSCA_LOADER_EN to also exercise the loader port.
module tb_estagio_busca;
  import isa_pkg::*;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;
  logic [19:0] exp_q[$];
  logic [15:0] mem [16];

  estagio_busca_if bus ();

  estagio_busca dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [15:0] prog_word(input logic [3:0] a);
    case (a)
      4'd0:    return 16'h40A0;
      4'd1:    return 16'h60A0;
      4'd2:    return 16'h40A0;
      4'd3:    return 16'h6120;
      4'd4:    return 16'h4520;
      4'd5:    return 16'h6530;
      4'd6:    return 16'h60A0;
      default: return 16'h0000;
    endcase
  endfunction

  // Instruction memory: synchronous reinit, registered read, write port
  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= prog_word(4'(i));
      bus.Mem_Q <= 16'h0000;
    end else begin
      if (bus.Mem_Wren) mem[bus.Mem_Address] <= bus.Mem_Din;
      bus.Mem_Q <= mem[bus.Mem_Address];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic rdy, input logic jmp, input logic [3:0] jt);
    @(posedge Clock);
    #2;
    bus.ID_Ready   = rdy;
    bus.Jump       = jmp;
    bus.JumpTarget = jt;
  endtask

  task automatic push(input logic [3:0] pc, input logic [15:0] w);
    exp_q.push_back({pc, w});
  endtask

  // Monitor: every accepted word must match the head of the scoreboard
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge Clock);
      if (bus.IF_Valid === 1'b1 && bus.ID_Ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer pc=%h instr=%h", bus.PC_out, bus.Instr);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_pc", 32'(bus.PC_out), 32'(e[19:16]));
          chk("xfer_instr", 32'(bus.Instr), 32'(e[15:0]));
        end
      end else if (bus.IF_Valid === 1'b0) begin
        chk("nop_when_invalid", 32'(bus.Instr), 32'h0000);
      end
    end
  end

  initial begin
    checks         = 0;
    errors         = 0;
    Reset          = 1'b1;
    bus.ID_Ready   = 1'b1;
    bus.Jump       = 1'b0;
    bus.JumpTarget = 4'd0;
`ifdef BUSCA_LOADER_EN
    bus.Load_Valid = 1'b0;
    bus.Load_Addr  = 4'd0;
    bus.Load_Data  = 16'h0000;
`endif
    repeat (2) @(posedge Clock);
    #2;
    chk("rst_if_valid", 32'(bus.IF_Valid), 32'd0);
    chk("rst_instr", 32'(bus.Instr), 32'h0000);
    chk("rst_pc_out", 32'(bus.PC_out), 32'd0);
    chk("rst_mem_addr", 32'(bus.Mem_Address), 32'd0);
    chk("rst_mem_wren", 32'(bus.Mem_Wren), 32'd0);
    chk("rst_mem_din", 32'(bus.Mem_Din), 32'h0000);
    Reset = 1'b0;
    push(4'd0, 16'h40A0);
    @(negedge Clock);
    chk("prime_bubble", 32'(bus.IF_Valid), 32'd0);
    chk("prime_addr", 32'(bus.Mem_Address), 32'd0);

    cyc(1'b1, 1'b0, 4'd0);
    push(4'd1, 16'h60A0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 4'd0);
      @(negedge Clock);
      chk("stall_valid", 32'(bus.IF_Valid), 32'd1);
      chk("stall_instr", 32'(bus.Instr), 32'h60A0);
      chk("stall_pc", 32'(bus.PC_out), 32'd1);
      chk("stall_addr", 32'(bus.Mem_Address), 32'd1);
    end
    cyc(1'b1, 1'b0, 4'd0);

    // PC=2 is squashed by the redirect to 6
    push(4'd6, 16'h60A0);
    push(4'd7, 16'h0000);
    cyc(1'b1, 1'b1, 4'd6);
    @(negedge Clock);
    chk("jump_squash", 32'(bus.IF_Valid), 32'd0);
    chk("jump_addr", 32'(bus.Mem_Address), 32'd6);
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 4'd0);

    // Redirect while decode is stalled
    push(4'd3, 16'h6120);
    cyc(1'b0, 1'b1, 4'd3);
    @(negedge Clock);
    chk("jump_stall_valid", 32'(bus.IF_Valid), 32'd0);
    chk("jump_stall_addr", 32'(bus.Mem_Address), 32'd3);
    cyc(1'b1, 1'b0, 4'd0);

    // Hold PC=4, then pulse Reset between edges
    cyc(1'b0, 1'b0, 4'd0);
    @(negedge Clock);
    chk("pre_reset_pc", 32'(bus.PC_out), 32'd4);
    chk("pre_reset_valid", 32'(bus.IF_Valid), 32'd1);
    #1 Reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.IF_Valid), 32'd0);
    chk("midrst_pc", 32'(bus.PC_out), 32'd0);
    chk("midrst_instr", 32'(bus.Instr), 32'h0000);
    chk("midrst_addr", 32'(bus.Mem_Address), 32'd0);
    #1 Reset = 1'b0;
    for (int i = 0; i < 20; i++) push(4'(i % 16), prog_word(4'(i % 16)));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      @(negedge Clock);
      chk("run_valid", 32'(bus.IF_Valid), 32'd1);
    end

`ifdef BUSCA_LOADER_EN
    @(posedge Clock);
    #2;
    bus.Load_Valid = 1'b1;
    bus.Load_Addr  = 4'd3;
    bus.Load_Data  = 16'h1234;
    @(negedge Clock);
    chk("load_wren", 32'(bus.Mem_Wren), 32'd1);
    chk("load_addr", 32'(bus.Mem_Address), 32'd3);
    chk("load_din", 32'(bus.Mem_Din), 32'h1234);
    chk("load_valid_low", 32'(bus.IF_Valid), 32'd0);
    @(posedge Clock);
    #2;
    bus.Load_Valid = 1'b0;
    push(4'd0, 16'h40A0);
    push(4'd1, 16'h60A0);
    push(4'd2, 16'h40A0);
    push(4'd3, 16'h1234);
    @(negedge Clock);
    chk("load_exit_wren", 32'(bus.Mem_Wren), 32'd0);
    chk("load_exit_valid", 32'(bus.IF_Valid), 32'd0);
    repeat (5) cyc(1'b1, 1'b0, 4'd0);
    @(negedge Clock);
`endif

    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    bus.ID_Ready = 1'b0;
    repeat (2) @(posedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
